// File: rtl/drum_pkg.sv
// Shared types and sample-format helpers for the drum voice path.
package drum_pkg;

  localparam int unsigned SAMPLE_W = 8;
  localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'h80;

  typedef enum logic [1:0] {
    MIX_IDLE,
    MIX_ACCUM,
    MIX_SCALE,
    MIX_OUT
  } mixer_state_t;

  // Offset-binary sample to two's complement (v - 128).
  function automatic logic signed [SAMPLE_W-1:0] to_signed8(input logic [SAMPLE_W-1:0] v);
    return {~v[SAMPLE_W-1], v[SAMPLE_W-2:0]};
  endfunction

  // Two's complement back to offset-binary (s + 128).
  function automatic logic [SAMPLE_W-1:0] to_offset8(input logic signed [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0]};
  endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Voice mixer control/data bundle; peak/peak_clr exist only with MIXER_PEAK_EN.
interface voice_mixer_if #(
  parameter int unsigned NUM_VOICES = 4
);
  logic                    sample_tick;
  logic [8*NUM_VOICES-1:0] voice_in;
  logic [NUM_VOICES-1:0]   voice_active;
  logic [2:0]              atten;
  logic                    clr_overrun;
  logic [7:0]              duty_out;
  logic                    out_valid;
  logic                    busy;
  logic                    overrun;
`ifdef MIXER_PEAK_EN
  logic [7:0]              peak;
  logic                    peak_clr;

  modport master (
    output sample_tick, voice_in, voice_active, atten, clr_overrun, peak_clr,
    input  duty_out, out_valid, busy, overrun, peak
  );
  modport slave (
    input  sample_tick, voice_in, voice_active, atten, clr_overrun, peak_clr,
    output duty_out, out_valid, busy, overrun, peak
  );
`else
  modport master (
    output sample_tick, voice_in, voice_active, atten, clr_overrun,
    input  duty_out, out_valid, busy, overrun
  );
  modport slave (
    input  sample_tick, voice_in, voice_active, atten, clr_overrun,
    output duty_out, out_valid, busy, overrun
  );
`endif
endinterface

// File: rtl/voice_mixer_saturate.sv
// Attenuates the mix accumulator by an arithmetic shift and clips to signed 8 bits.
module mixer_saturate
  import drum_pkg::*;
#(
  parameter int unsigned ACC_W = 11
) (
  input  logic signed [ACC_W-1:0]    acc,
  input  logic        [2:0]          shift,
  output logic signed [SAMPLE_W-1:0] sat_c
);

  localparam logic signed [ACC_W-1:0] POS_MAX = ACC_W'(127);
  localparam logic signed [ACC_W-1:0] NEG_MIN = ACC_W'(-128);

  logic signed [ACC_W-1:0] shifted;

  always_comb begin
    shifted = acc >>> shift;
    if (shifted > POS_MAX) begin
      sat_c = 8'sh7F;
    end else if (shifted < NEG_MIN) begin
      sat_c = 8'sh80;
    end else begin
      sat_c = SAMPLE_W'(shifted);
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Serial N-voice mixer feeding pwm duty; one adder, one voice per cycle.
// Optional peak meter is built when MIXER_PEAK_EN is defined.
module voice_mixer
  import drum_pkg::*;
#(
  parameter int unsigned NUM_VOICES = 4
) (
  input  logic          clk,
  input  logic          rst,
  voice_mixer_if.slave  bus
);

  localparam int unsigned ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  mixer_state_t             state_q, state_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [SAMPLE_W-1:0]      voice_snap_q [NUM_VOICES];
  logic [SAMPLE_W-1:0]      voice_snap_d [NUM_VOICES];
  logic [NUM_VOICES-1:0]    act_snap_q, act_snap_d;
  logic [2:0]               atten_snap_q, atten_snap_d;
  logic [SAMPLE_W-1:0]      duty_q, duty_d;
  logic                     valid_q, valid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic signed [SAMPLE_W-1:0] sat_c;

  mixer_saturate #(.ACC_W(ACC_W)) u_sat (
    .acc   (acc_q),
    .shift (atten_snap_q),
    .sat_c (sat_c)
  );

  // Next-state and datapath updates
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    idx_d        = idx_q;
    voice_snap_d = voice_snap_q;
    act_snap_d   = act_snap_q;
    atten_snap_d = atten_snap_q;
    duty_d       = duty_q;
    valid_d      = 1'b0;
    overrun_d    = overrun_q;

    // A dropped tick beats a simultaneous clear
    if (bus.sample_tick && (state_q != MIX_IDLE)) begin
      overrun_d = 1'b1;
    end else if (bus.clr_overrun) begin
      overrun_d = 1'b0;
    end

    case (state_q)
      MIX_IDLE: begin
        if (bus.sample_tick) begin
          for (int v = 0; v < int'(NUM_VOICES); v++) begin
            voice_snap_d[v] = bus.voice_in[8*v +: 8];
          end
          act_snap_d   = bus.voice_active;
          atten_snap_d = bus.atten;
          acc_d        = '0;
          idx_d        = '0;
          state_d      = MIX_ACCUM;
        end
      end
      MIX_ACCUM: begin
        if (act_snap_q[idx_q]) begin
          acc_d = acc_q + ACC_W'(to_signed8(voice_snap_q[idx_q]));
        end
        idx_d = IDX_W'(idx_q + 1'b1);
        if (idx_q == IDX_W'(NUM_VOICES - 1)) begin
          state_d = MIX_SCALE;
        end
      end
      MIX_SCALE: begin
        duty_d  = to_offset8(sat_c);
        valid_d = 1'b1;
        state_d = MIX_OUT;
      end
      MIX_OUT: begin
        state_d = MIX_IDLE;
      end
      default: begin
        state_d = MIX_IDLE;
      end
    endcase

    busy_d = (state_d != MIX_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= MIX_IDLE;
      acc_q        <= '0;
      idx_q        <= '0;
      voice_snap_q <= '{default: '0};
      act_snap_q   <= '0;
      atten_snap_q <= '0;
      duty_q       <= SAMPLE_MID;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      idx_q        <= idx_d;
      voice_snap_q <= voice_snap_d;
      act_snap_q   <= act_snap_d;
      atten_snap_q <= atten_snap_d;
      duty_q       <= duty_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.duty_out  = duty_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;

`ifdef MIXER_PEAK_EN
  logic [SAMPLE_W-1:0] peak_q, peak_d;
  logic [SAMPLE_W-1:0] mag_c;

  // Peak magnitude meter; |-128| = 128 fits unsigned 8 bits
  always_comb begin
    mag_c  = sat_c[SAMPLE_W-1] ? SAMPLE_W'(-sat_c) : SAMPLE_W'(sat_c);
    peak_d = peak_q;
    if (state_q == MIX_SCALE) begin
      if (bus.peak_clr || (mag_c > peak_q)) begin
        peak_d = mag_c;
      end
    end else if (bus.peak_clr) begin
      peak_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      peak_q <= '0;
    end else begin
      peak_q <= peak_d;
    end
  end

  assign bus.peak = peak_q;
`endif

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: vector table plus overrun, snapshot, reset and peak sequences.
module tb_voice_mixer;

  localparam int unsigned NV = 4;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  voice_mixer_if #(.NUM_VOICES(NV)) bus ();

  voice_mixer #(.NUM_VOICES(NV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] voices;
    logic [3:0]  act;
    logic [2:0]  atten;
    logic [7:0]  exp_duty;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Tick at edge 0, then count edges until out_valid shows (bounded)
  task automatic run_mix(input logic [31:0] v, input logic [3:0] a, input logic [2:0] at,
                         output logic [7:0] duty, output int lat);
    @(negedge clk);
    bus.voice_in     = v;
    bus.voice_active = a;
    bus.atten        = at;
    bus.sample_tick  = 1'b1;
    @(posedge clk);
    #1 bus.sample_tick = 1'b0;
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    duty = bus.duty_out;
  endtask

  logic [7:0] duty;
  int         lat;
  int         pulses;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.sample_tick  = 1'b0;
    bus.voice_in     = '0;
    bus.voice_active = '0;
    bus.atten        = '0;
    bus.clr_overrun  = 1'b0;
`ifdef MIXER_PEAK_EN
    bus.peak_clr     = 1'b0;
`endif

    vecs[0] = '{32'h12345678, 4'b0000, 3'd0, 8'h80};
    vecs[1] = '{32'hFFFFFFFF, 4'b1111, 3'd0, 8'hFF};
    vecs[2] = '{32'hFFFFFFFF, 4'b1111, 3'd3, 8'hBF};
    vecs[3] = '{32'h00000000, 4'b1111, 3'd0, 8'h00};
    vecs[4] = '{32'h000000A0, 4'b0001, 3'd0, 8'hA0};
    vecs[5] = '{32'h00007090, 4'b0011, 3'd0, 8'h80};
    vecs[6] = '{32'h000000C0, 4'b0001, 3'd1, 8'hA0};
    vecs[7] = '{32'h00000000, 4'b0001, 3'd7, 8'h7F};
    vecs[8] = '{32'h81818181, 4'b1111, 3'd0, 8'h84};
    vecs[9] = '{32'hFF000000, 4'b1111, 3'd2, 8'h3F};

    repeat (3) @(posedge clk);
    #1;
    check("rst_duty", 32'(bus.duty_out), 32'h80);
    check("rst_valid", 32'(bus.out_valid), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_overrun", 32'(bus.overrun), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_mix(vecs[i].voices, vecs[i].act, vecs[i].atten, duty, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(NV + 1));
      check($sformatf("vec%0d_duty", i), 32'(duty), 32'(vecs[i].exp_duty));
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valid_drop", i), 32'(bus.out_valid), 32'h0);
      check($sformatf("vec%0d_busy_low", i), 32'(bus.busy), 32'h0);
    end

    // Second tick while busy is dropped and flags overrun
    @(negedge clk);
    bus.voice_in = 32'h000000C0; bus.voice_active = 4'b0001; bus.atten = 3'd0;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1 bus.sample_tick = 1'b0;
    check("busy_during_mix", 32'(bus.busy), 32'h1);
    @(posedge clk); #1 bus.sample_tick = 1'b1;
    @(posedge clk); #1 bus.sample_tick = 1'b0;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    check("overrun_single_valid", 32'(pulses), 32'd1);
    check("overrun_set", 32'(bus.overrun), 32'h1);
    check("overrun_duty", 32'(bus.duty_out), 32'hC0);
    @(negedge clk); bus.clr_overrun = 1'b1;
    @(posedge clk); #1 bus.clr_overrun = 1'b0;
    check("overrun_cleared", 32'(bus.overrun), 32'h0);

    // Dropped tick and clear in the same cycle: set wins
    @(negedge clk); bus.sample_tick = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b1; bus.clr_overrun = 1'b1;
    @(posedge clk); #1;
    bus.sample_tick = 1'b0; bus.clr_overrun = 1'b0;
    check("overrun_set_wins", 32'(bus.overrun), 32'h1);
    repeat (8) @(posedge clk);
    @(negedge clk); bus.clr_overrun = 1'b1;
    @(posedge clk); #1 bus.clr_overrun = 1'b0;
    check("overrun_clear2", 32'(bus.overrun), 32'h0);

    // Inputs changed mid-mix must not affect the snapshot
    @(negedge clk);
    bus.voice_in = 32'h000000A0; bus.voice_active = 4'b0001; bus.atten = 3'd0;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1 bus.sample_tick = 1'b0;
    @(posedge clk); #1;
    bus.voice_in = 32'hFFFFFFFF; bus.voice_active = 4'b1111; bus.atten = 3'd3;
    lat = -1;
    for (int k = 2; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = k;
        break;
      end
    end
    check("snapshot_latency", 32'(lat), 32'(NV + 1));
    check("snapshot_duty", 32'(bus.duty_out), 32'hA0);
    repeat (2) @(posedge clk);

    // Reset mid-mix discards the partial result
    @(negedge clk);
    bus.voice_in = 32'hFFFFFFFF; bus.voice_active = 4'b1111; bus.atten = 3'd0;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1 bus.sample_tick = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("midrst_duty", 32'(bus.duty_out), 32'h80);
    check("midrst_busy", 32'(bus.busy), 32'h0);
    @(negedge clk); rst = 1'b0;
    pulses = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus.out_valid) pulses++;
    end
    check("midrst_no_valid", 32'(pulses), 32'd0);
    check("midrst_duty_held", 32'(bus.duty_out), 32'h80);

`ifdef MIXER_PEAK_EN
    check("peak_rst", 32'(bus.peak), 32'h0);
    run_mix(32'h00000040, 4'b0001, 3'd0, duty, lat);
    check("peak_mix40_duty", 32'(duty), 32'h40);
    run_mix(32'h000000C0, 4'b0001, 3'd0, duty, lat);
    check("peak_after_two", 32'(bus.peak), 32'd64);
    repeat (2) @(posedge clk);
    // peak_clr during SCALE loads the new magnitude directly
    @(negedge clk);
    bus.voice_in = 32'h000000A0; bus.voice_active = 4'b0001; bus.atten = 3'd0;
    bus.sample_tick = 1'b1;
    @(posedge clk); #1 bus.sample_tick = 1'b0;
    repeat (NV) @(posedge clk);
    #1 bus.peak_clr = 1'b1;
    @(posedge clk); #1 bus.peak_clr = 1'b0;
    check("peak_clr_in_scale_valid", 32'(bus.out_valid), 32'h1);
    check("peak_clr_in_scale", 32'(bus.peak), 32'd32);
    repeat (2) @(posedge clk);
    @(negedge clk); bus.peak_clr = 1'b1;
    @(posedge clk); #1 bus.peak_clr = 1'b0;
    check("peak_clr_alone", 32'(bus.peak), 32'h0);
    run_mix(32'h00000000, 4'b1111, 3'd0, duty, lat);
    check("peak_neg_full", 32'(bus.peak), 32'd128);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
